// File: rtl/vproc_div_iter.sv
// vproc_div_iter: multi-cycle radix-2 restoring divider for one vector lane.
// Signed/unsigned DIV/REM with RISC-V divide-by-zero and overflow results.
// Optional macro VPROC_DIV_ITER_EARLY_OUT_EN skips leading zeros of |op1|.
module vproc_div_iter #(
  parameter int unsigned DIV_W  = 32,
  parameter type         CTRL_T = logic
) (
  input  logic             clk_i,
  input  logic             async_rst_ni,
  input  logic             sync_rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  CTRL_T            in_ctrl_i,
  input  logic [DIV_W-1:0] in_op1_i,
  input  logic [DIV_W-1:0] in_op2_i,
  input  logic             in_signed_i,
  input  logic             in_rem_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output CTRL_T            out_ctrl_o,
  output logic [DIV_W-1:0] out_res_o
);

  localparam int unsigned CNT_W = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [DIV_W-1:0] dvd_q;      // dividend, becomes quotient as bits shift in
  logic [DIV_W-1:0] rem_q;      // partial remainder
  logic [DIV_W-1:0] dvs_q;      // |divisor|
  logic             rem_sel_q;
  logic             res_neg_q;
  CTRL_T            ctrl_q;
  logic [DIV_W-1:0] out_res_q;
  CTRL_T            out_ctrl_q;

  logic             accept;
  logic             op1_neg, op2_neg;
  logic [DIV_W-1:0] abs1, abs2;
  logic             div_zero, ovfl, shortcut;
  logic [DIV_W-1:0] short_q, short_r;
  logic [DIV_W-1:0] dvd_init;
  logic [CNT_W-1:0] cnt_init;
  logic [DIV_W:0]   r_sh;
  logic             ge;
  logic [DIV_W-1:0] diff;
  logic [DIV_W-1:0] res_abs, res_fin;

`ifdef VPROC_DIV_ITER_EARLY_OUT_EN
  // Leading-zero count of a DIV_W-bit value (DIV_W for zero)
  function automatic logic [CNT_W-1:0] clz(input logic [DIV_W-1:0] v);
    logic [CNT_W-1:0] n;
    logic             found;
    n     = '0;
    found = 1'b0;
    for (int i = DIV_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n     = n + CNT_W'(1);
      end
    end
    return n;
  endfunction

  logic [CNT_W-1:0] lz;
`endif

  // Operand conditioning and special-case detection on the accepting edge
  always_comb begin
    accept   = (state_q == IDLE) && in_valid_i;
    op1_neg  = in_signed_i & in_op1_i[DIV_W-1];
    op2_neg  = in_signed_i & in_op2_i[DIV_W-1];
    abs1     = op1_neg ? -in_op1_i : in_op1_i;
    abs2     = op2_neg ? -in_op2_i : in_op2_i;
    div_zero = (in_op2_i == '0);
    ovfl     = in_signed_i & (in_op1_i == {1'b1, {(DIV_W-1){1'b0}}}) & (in_op2_i == '1);
    short_q  = div_zero ? '1 : (ovfl ? in_op1_i : '0);
    short_r  = div_zero ? in_op1_i : '0;
`ifdef VPROC_DIV_ITER_EARLY_OUT_EN
    lz       = clz(abs1);
    shortcut = div_zero | ovfl | (abs1 == '0);
    dvd_init = abs1 << lz;
    cnt_init = CNT_W'(DIV_W) - lz;
`else
    shortcut = div_zero | ovfl;
    dvd_init = abs1;
    cnt_init = CNT_W'(DIV_W);
`endif
  end

  // One restoring step plus final sign fix-up
  always_comb begin
    r_sh    = {rem_q, dvd_q[DIV_W-1]};
    ge      = r_sh >= {1'b0, dvs_q};
    diff    = DIV_W'(r_sh - {1'b0, dvs_q});
    res_abs = rem_sel_q ? rem_q : dvd_q;
    res_fin = res_neg_q ? -res_abs : res_abs;
  end

  // Control FSM; counter value 0 in BUSY is the result-forming cycle
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (!sync_rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
            cnt_q      <= shortcut ? '0 : cnt_init;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers (no reset): load, iterate, form result
  always_ff @(posedge clk_i) begin
    if (accept) begin
      ctrl_q    <= in_ctrl_i;
      rem_sel_q <= in_rem_i;
      dvs_q     <= abs2;
      if (shortcut) begin
        dvd_q     <= short_q;
        rem_q     <= short_r;
        res_neg_q <= 1'b0;
      end else begin
        dvd_q     <= dvd_init;
        rem_q     <= '0;
        res_neg_q <= in_rem_i ? op1_neg : (op1_neg ^ op2_neg);
      end
    end else if (state_q == BUSY) begin
      if (cnt_q != '0) begin
        dvd_q <= {dvd_q[DIV_W-2:0], ge};
        rem_q <= ge ? diff : r_sh[DIV_W-1:0];
      end else begin
        out_res_q  <= res_fin;
        out_ctrl_q <= ctrl_q;
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_res_o   = out_res_q;
  assign out_ctrl_o  = out_ctrl_q;

endmodule

// File: tb/tb_vproc_div_iter.sv
// Randomized self-checking bench for vproc_div_iter against an arithmetic model.
module tb_vproc_div_iter;

  localparam int unsigned W = 32;
  typedef logic [7:0] ctrl_t;

  logic         clk;
  logic         arst_n;
  logic         srst_n;
  logic         in_valid;
  logic         in_ready;
  ctrl_t        in_ctrl;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         in_signed;
  logic         in_rem;
  logic         out_valid;
  logic         out_ready;
  ctrl_t        out_ctrl;
  logic [W-1:0] out_res;

  int n_vec;
  int n_err;

  vproc_div_iter #(
    .DIV_W  (W),
    .CTRL_T (ctrl_t)
  ) dut (
    .clk_i        (clk),
    .async_rst_ni (arst_n),
    .sync_rst_ni  (srst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_ctrl_i    (in_ctrl),
    .in_op1_i     (op1),
    .in_op2_i     (op2),
    .in_signed_i  (in_signed),
    .in_rem_i     (in_rem),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_ctrl_o   (out_ctrl),
    .out_res_o    (out_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RISC-V division semantics with plain arithmetic
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sg, input logic rm);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else if (sg) begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return rm ? r : q;
  endfunction

  // Edges after the accepting edge until out_valid is seen
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
    logic [W-1:0] m;
    int           n;
    if (b == '0) return 1;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef VPROC_DIV_ITER_EARLY_OUT_EN
    m = (sg && a[W-1]) ? -a : a;
    if (m == '0) return 1;
    n = 0;
    while (m != '0) begin
      m = m >> 1;
      n++;
    end
    return n + 1;
`else
    m = a;
    n = int'(m[0]) * 0;
    return W + 1 + n;
`endif
  endfunction

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("in_ready_idle", in_ready, 1'b1);
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                        input logic rm, input ctrl_t c);
    wait_ready();
    op1       = a;
    op2       = b;
    in_signed = sg;
    in_rem    = rm;
    in_ctrl   = c;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    op1       = $urandom;
    op2       = $urandom;
    in_signed = 1'($urandom);
    in_rem    = 1'($urandom);
    in_ctrl   = ctrl_t'($urandom);
    check("in_ready_busy", in_ready, 1'b0);
  endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         input logic rm, input ctrl_t c, input int hold);
    int           lat;
    logic [W-1:0] exp;
    exp = ref_res(a, b, sg, rm);
    accept(a, b, sg, rm, c);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat(a, b, sg));
    check("result", out_res, exp);
    check("ctrl", out_ctrl, c);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_res", out_res, exp);
      check("hold_ctrl", out_ctrl, c);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_valid", out_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         seen;
    n_vec     = 0;
    n_err     = 0;
    arst_n    = 1'b0;
    srst_n    = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    op1       = '0;
    op2       = '0;
    in_signed = 1'b0;
    in_rem    = 1'b0;
    out_ready = 1'b0;

    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    #10;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_out_valid", out_valid, 1'b0);

    // Directed cases
    run_txn(32'd100, 32'd7, 1'b0, 1'b0, 8'h11, 0);
    run_txn(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 8'h22, 0);
    run_txn(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, 8'h33, 0);
    run_txn(32'h1234_5678, 32'd0, 1'b0, 1'b0, 8'h44, 0);
    run_txn(32'h1234_5678, 32'd0, 1'b1, 1'b1, 8'h45, 0);
    run_txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 8'h55, 0);
    run_txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 8'h56, 0);
    run_txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h57, 0);
    run_txn(32'd1000, 32'd3, 1'b0, 1'b0, 8'h66, 10);
    run_txn(32'd3, 32'd1, 1'b0, 1'b0, 8'h77, 0);
    run_txn(32'd0, 32'd5, 1'b1, 1'b0, 8'h88, 0);
    run_txn(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 8'h99, 1);

    // Synchronous flush mid-BUSY drops the transaction
    accept(32'd100, 32'd7, 1'b0, 1'b0, 8'hA0);
    repeat (4) @(posedge clk);
    #1;
    srst_n = 1'b0;
    @(posedge clk);
    #1;
    srst_n = 1'b1;
    check("srst_in_ready", in_ready, 1'b1);
    check("srst_out_valid", out_valid, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check("srst_no_result", seen, 1'b0);
    run_txn(32'd77, 32'd5, 1'b0, 1'b1, 8'hA1, 0);

    // Asynchronous reset mid-BUSY
    accept(32'hFFFF_0000, 32'd9, 1'b1, 1'b0, 8'hB0);
    repeat (3) @(posedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_valid", out_valid, 1'b0);
    #1;
    arst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check("arst_no_result", seen, 1'b0);

    // Randomized transactions with corner-biased operands
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = '1;
        2:       b = W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = W'($urandom_range(0, 255));
        2:       a = '0;
        default: a = $urandom;
      endcase
      run_txn(a, b, 1'($urandom), 1'($urandom), ctrl_t'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
